clk_div3: RTL and testbench



---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div3_if.sv | 20 ++
 rtl/clk_div_counter.sv | 31 +++
 rtl/clk_div3.sv | 67 ++++++
 tb/tb_clk_div3.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock dividers.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;
  localparam int unsigned DIV_MAX = 256;

  // Number of input cycles the divided clock spends high in the base build.
  function automatic int unsigned high_cycles(input int unsigned div);
    return (div / 2 < 1) ? 1 : div / 2;
  endfunction

endpackage

// File: rtl/clk_div3_if.sv
// Enable/output bundle of the divide-by-DIV clock generator.
interface clk_div3_if;

  logic enable;
  logic clock_out;
  logic tick_out;

  modport master (
    output enable,
    input  clock_out,
    input  tick_out
  );

  modport slave (
    input  enable,
    output clock_out,
    output tick_out
  );

endinterface

// File: rtl/clk_div_counter.sv
// Modulo-DIV up-counter with enable, synchronous reset to DIV-1 and terminal count.
module clk_div_counter #(
  parameter  int unsigned DIV = 3,
  localparam int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count_nxt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Any encoding at or above LAST folds back to zero on the next enabled edge.
  always_comb begin
    tc        = (count == LAST);
    count_nxt = (count >= LAST) ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
    end else if (en) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/clk_div3.sv
// Divide-by-DIV clock generator with terminal-count strobe.
// Define CLK_DIV3_DUTY50_EN to add a falling-edge stage giving 50 % duty for odd DIV.
module clk_div3
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  clk_div3_if.slave  bus
);

  localparam int unsigned   CW     = $clog2(DIV);
  localparam int unsigned   HIGH   = high_cycles(DIV);
  localparam logic [CW-1:0] HIGH_C = CW'(HIGH);

  if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
    $error("clk_div3: DIV=%0d outside legal range %0d..%0d", DIV, DIV_MIN, DIV_MAX);
  end

  logic [CW-1:0] count_nxt;
  logic          tc;
  logic          out_q;

  clk_div_counter #(
    .DIV (DIV)
  ) u_counter (
    .clk       (clock_in),
    .rst       (reset),
    .en        (bus.enable),
    .count_nxt (count_nxt),
    .tc        (tc)
  );

  // Decoding the next count keeps out_q aligned with count without output glitches.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      out_q <= 1'b0;
    end else if (bus.enable) begin
      out_q <= (count_nxt < HIGH_C);
    end
  end

`ifdef CLK_DIV3_DUTY50_EN
  if (DIV % 2 == 1) begin : g_duty50
    logic neg_q;

    // Stretches the high phase by half an input cycle.
    always_ff @(negedge clock_in) begin
      if (reset) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= out_q;
      end
    end

    assign bus.clock_out = out_q | neg_q;
  end else begin : g_even
    assign bus.clock_out = out_q;
  end
`else
  assign bus.clock_out = out_q;
`endif

  assign bus.tick_out = bus.enable & ~reset & tc;

endmodule

// File: tb/tb_clk_div3.sv
// Randomized self-checking bench for clk_div3 at DIV = 3, 4 and 2.
`timescale 1ns/1ps
module tb_clk_div3;

  localparam int NI = 3;
  localparam int DIVS [NI] = '{3, 4, 2};
`ifdef CLK_DIV3_DUTY50_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div3_if if3 ();
  clk_div3_if if4 ();
  clk_div3_if if2 ();

  assign if3.enable = en;
  assign if4.enable = en;
  assign if2.enable = en;

  clk_div3 #(.DIV(3)) u_d3 (.clock_in(clk), .reset(rst), .bus(if3));
  clk_div3 #(.DIV(4)) u_d4 (.clock_in(clk), .reset(rst), .bus(if4));
  clk_div3 #(.DIV(2)) u_d2 (.clock_in(clk), .reset(rst), .bus(if2));

  always #500 clk = ~clk;

  logic co [NI];
  logic tk [NI];
  always_comb begin
    co[0] = if3.clock_out; tk[0] = if3.tick_out;
    co[1] = if4.clock_out; tk[1] = if4.tick_out;
    co[2] = if2.clock_out; tk[2] = if2.tick_out;
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: position within the output period and the resulting level.
  int ph [NI];
  bit mo [NI];
  bit nq [NI];
  bit armed = 1'b0;

  function automatic bit exp_co(input int k);
    return (DUTY && (DIVS[k] % 2 == 1)) ? (mo[k] | nq[k]) : mo[k];
  endfunction

  function automatic bit exp_tk(input int k);
    return en && !rst && (ph[k] == DIVS[k] - 1);
  endfunction

  task automatic compare_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_co_div%0d", tag, DIVS[k]), co[k], exp_co(k));
      check($sformatf("%s_tk_div%0d", tag, DIVS[k]), tk[k], exp_tk(k));
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        ph[k] = DIVS[k] - 1;
        mo[k] = 1'b0;
      end else if (en) begin
        ph[k] = (ph[k] + 1) % DIVS[k];
        mo[k] = ph[k] < DIVS[k] / 2;
      end
    end
    if (rst) armed = 1'b1;
    #1;
    if (armed) compare_all("pos");
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) nq[k] = rst ? 1'b0 : mo[k];
    #1;
    if (armed) compare_all("neg");
  end

  // Hand-derived waveforms sampled mid-cycle, starting with the cycle reset is released.
  logic pin_co3 [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic pin_tk3 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic pin_co4 [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic pin_tk4 [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic pin_co2 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic pin_tk2 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_co_div%0d", DIVS[k]), co[k], 1'b0);
      check($sformatf("reset_tk_div%0d", DIVS[k]), tk[k], 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      check($sformatf("pin_co_div3_%0d", i), co[0], pin_co3[i]);
      check($sformatf("pin_tk_div3_%0d", i), tk[0], pin_tk3[i]);
      check($sformatf("pin_co_div4_%0d", i), co[1], pin_co4[i]);
      check($sformatf("pin_tk_div4_%0d", i), tk[1], pin_tk4[i]);
      check($sformatf("pin_co_div2_%0d", i), co[2], pin_co2[i]);
      check($sformatf("pin_tk_div2_%0d", i), tk[2], pin_tk2[i]);
    end

    repeat (14) @(posedge clk);
    #2 en = 1'b0;
    repeat (4) @(posedge clk);
    #2 en = 1'b1;

    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    repeat (2000) begin
      @(posedge clk);
      #2;
      en  = ($urandom % 4) != 0;
      rst = ($urandom % 25) == 0;
    end

    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(posedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
